// File: rtl/demux_stream.sv
// demux_stream: 1-to-N registered stream demultiplexer, one single-entry slot per output.
// Broadcast to all outputs is available when DEMUX_BCAST_EN is defined.
module demux_stream #(
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic [SW-1:0]            in_sel,
    input  logic                     in_bcast,
    output logic [(2**SW)-1:0]       out_valid,
    input  logic [(2**SW)-1:0]       out_ready,
    output logic [(2**SW)*W-1:0]     out_data
);
    localparam int N = 2**SW;

    logic [N-1:0]        valid_q;
    logic [N-1:0]        valid_d;
    logic [N-1:0][W-1:0] data_q;
    logic [N-1:0][W-1:0] data_d;
    logic [N-1:0]        free_s;
    logic [N-1:0]        load_s;
    logic                bcast_s;
    logic                accept_s;

`ifdef DEMUX_BCAST_EN
    assign bcast_s = in_bcast;
`else
    logic unused_bcast_s;
    assign unused_bcast_s = in_bcast;
    assign bcast_s        = 1'b0;
`endif

    // A slot can take a new beat if it is empty or is being drained this cycle.
    assign free_s   = ~valid_q | out_ready;
    assign in_ready = bcast_s ? (&free_s) : free_s[in_sel];
    assign accept_s = in_valid & in_ready;

    // Per-slot load selection and next state; a drain plus load keeps valid high.
    always_comb begin
        load_s  = {N{1'b0}};
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < N; k++) begin
            if (accept_s && (bcast_s || (in_sel == SW'(k)))) begin
                load_s[k] = 1'b1;
            end else begin
                load_s[k] = 1'b0;
            end
            if (load_s[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Slot registers; reset discards every held beat immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {N{1'b0}};
            data_q  <= {(N*W){1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus random traffic
// compared every cycle against a slot-occupancy model of the demux.
module tb_demux_stream;
    localparam int W  = 8;
    localparam int SW = 2;
    localparam int N  = 4;
`ifdef DEMUX_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [SW-1:0]  in_sel;
    logic           in_bcast;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each output holds at most one beat plus the last value it was given.
    bit           occ  [N];
    logic [W-1:0] held [N];

    demux_stream #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            occ[k]  = 1'b0;
            held[k] = 8'h00;
        end
    endtask

    task automatic check_outputs(input logic exp_rdy);
        logic [N-1:0] ev;
        for (int k = 0; k < N; k++) ev[k] = occ[k];
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, ev);
        for (int k = 0; k < N; k++)
            chk($sformatf("out_data[%0d]", k), out_data[k*W +: W], held[k]);
    endtask

    // One cycle: drive at negedge, compare, then advance the model across the posedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                         input logic b, input logic [N-1:0] r);
        logic exp_rdy;
        logic bc;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        out_ready = r;
        #1;
        bc = BCAST && b;
        if (bc) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < N; k++) if (occ[k] && !r[k]) exp_rdy = 1'b0;
        end else begin
            exp_rdy = !occ[s] || r[s];
        end
        check_outputs(exp_rdy);
        for (int k = 0; k < N; k++) begin
            if (occ[k] && r[k]) occ[k] = 1'b0;
            if (v && exp_rdy && (bc || int'(s) == k)) begin
                occ[k]  = 1'b1;
                held[k] = d;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0;
        in_bcast = 1'b0; out_ready = 4'h0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 4'b0000);
        chk("reset_out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);

        // Unicast steer
        cycle(1'b1, 8'hA5, 2'd2, 1'b0, 4'hF);
        after_edge();
        chk("steer_valid", out_valid, 4'b0100);
        chk("steer_data", out_data[23:16], 8'hA5);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        after_edge();
        chk("steer_clear", out_valid, 4'b0000);

        // Back-pressure on output 1
        cycle(1'b1, 8'h11, 2'd1, 1'b0, 4'b1101);
        cycle(1'b1, 8'h22, 2'd1, 1'b0, 4'b1101);
        chk("bp_stall", in_ready, 1'b0);
        cycle(1'b1, 8'h22, 2'd1, 1'b0, 4'b1111);
        chk("bp_first_out", out_data[15:8], 8'h11);
        chk("bp_release", in_ready, 1'b1);
        after_edge();
        chk("bp_second_valid", out_valid, 4'b0010);
        chk("bp_second_out", out_data[15:8], 8'h22);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // Independent drain
        cycle(1'b1, 8'h44, 2'd1, 1'b0, 4'b0000);
        cycle(1'b1, 8'h33, 2'd3, 1'b0, 4'b0000);
        chk("indep_ready", in_ready, 1'b1);
        after_edge();
        chk("indep_valid", out_valid, 4'b1010);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // Full-rate pass-through to output 0
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 2'd0, 1'b0, 4'b0001);
            chk("rate_ready", in_ready, 1'b1);
            if (i > 0) chk("rate_data", {out_valid[0], out_data[7:0]}, {1'b1, 8'(i - 1)});
        end
        after_edge();
        chk("rate_last", {out_valid[0], out_data[7:0]}, {1'b1, 8'h0F});
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

`ifdef DEMUX_BCAST_EN
        // Broadcast blocked by a stalled slot 3
        cycle(1'b1, 8'h77, 2'd3, 1'b0, 4'b0000);
        cycle(1'b1, 8'h5A, 2'd0, 1'b1, 4'b0111);
        chk("bcast_stall", in_ready, 1'b0);
        cycle(1'b1, 8'h5A, 2'd0, 1'b1, 4'b1111);
        chk("bcast_go", in_ready, 1'b1);
        after_edge();
        chk("bcast_valid", out_valid, 4'b1111);
        chk("bcast_data", out_data, 32'h5A5A5A5A);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
`endif

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                  $urandom_range(0, 7) == 0, 4'($urandom));
        end

        // Reset mid-stream with slots 0 and 2 full
        cycle(1'b1, 8'hAA, 2'd0, 1'b0, 4'b0000);
        cycle(1'b1, 8'hBB, 2'd2, 1'b0, 4'b0000);
        in_valid = 1'b0;
        after_edge();
        chk("pre_rst_valid", out_valid[2:0], 3'b101);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 4'b0000);
        chk("mid_rst_data", out_data, 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
